// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES loopback batch controller: state encoding,
// default block width, counter widths and a saturating increment helper.
package aes_ctrl_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int LAT_W      = 3;
  localparam int ERR_W      = 8;
  localparam int BLK_W      = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    ENC_WAIT = 3'd2,
    PUSH     = 3'd3,
    POP      = 3'd4,
    RD_WAIT  = 3'd5,
    DEC_WAIT = 3'd6,
    OUT      = 3'd7
  } state_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/aes_batch_ctrl_if.sv
// Bundle of the controller's plaintext stream, encrypt/decrypt core, FIFO
// control, result stream and status signals. "slave" is the controller's
// view, "master" is the surrounding environment's view.
interface aes_batch_ctrl_if
  import aes_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_key;
  logic              in_last;

  logic [DATA_W-1:0] enc_pt;
  logic [DATA_W-1:0] enc_key;
  logic [DATA_W-1:0] enc_ct;

  logic              fifo_we;
  logic              fifo_re;
  logic              fifo_full;
  logic              fifo_empty;

  logic [DATA_W-1:0] dec_key;
  logic [DATA_W-1:0] dec_pt;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_match;

  logic              busy;
  logic [ERR_W-1:0]  err_cnt;
  logic [BLK_W-1:0]  blk_cnt;
  logic              ovf_err;

  modport slave (
    input  in_valid, in_data, in_key, in_last,
    output in_ready,
    output enc_pt, enc_key,
    input  enc_ct,
    output fifo_we, fifo_re,
    input  fifo_full, fifo_empty,
    output dec_key,
    input  dec_pt,
    output out_valid, out_data, out_match,
    input  out_ready,
    output busy, err_cnt, blk_cnt, ovf_err
  );

  modport master (
    output in_valid, in_data, in_key, in_last,
    input  in_ready,
    input  enc_pt, enc_key,
    output enc_ct,
    input  fifo_we, fifo_re,
    output fifo_full, fifo_empty,
    input  dec_key,
    output dec_pt,
    input  out_valid, out_data, out_match,
    output out_ready,
    input  busy, err_cnt, blk_cnt, ovf_err
  );

endinterface

// File: rtl/aes_ref_queue.sv
// Ring buffer of plaintext blocks kept alongside the ciphertext FIFO so each
// decrypted block can be compared against the block that produced it.
module aes_ref_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  count;

  // Storage array; contents need no reset because occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + OCC_W'(1);
      end else if (pop && !push) begin
        count <= count - OCC_W'(1);
      end
    end
  end

  assign head = mem[rd_ptr];
  assign occ  = count;

endmodule

// File: rtl/aes_batch_ctrl.sv
// Batch sequencer for the AES loopback path: accepts plaintext beats under
// one key, runs each through the encrypt core into the FIFO, then drains the
// FIFO through the decrypt core and reports each block with a match flag.
module aes_batch_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 8,
  parameter int ENC_LAT = 1,
  parameter int RD_LAT  = 1,
  parameter int DEC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  aes_batch_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [LAT_W-1:0] ENC_END  = LAT_W'((ENC_LAT > 0) ? ENC_LAT - 1 : 0);
  localparam logic [LAT_W-1:0] RD_END   = LAT_W'((RD_LAT  > 0) ? RD_LAT  - 1 : 0);
  localparam logic [LAT_W-1:0] DEC_END  = LAT_W'((DEC_LAT > 0) ? DEC_LAT - 1 : 0);

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] pt_q;
  logic              last_q;
  logic [LAT_W-1:0]  lat_cnt;

  logic [DATA_W-1:0] out_data_q;
  logic              out_match_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic [BLK_W-1:0]  blk_cnt_q;
  logic              ovf_q;

  logic              in_ready_c;
  logic              accept;
  logic              fifo_we_c;
  logic              fifo_re_c;
  logic              q_push;
  logic              capture;
  logic              lat_inc;
  logic              ovf_set;
  logic              out_ack;

  logic [DATA_W-1:0] q_head;
  logic [OCC_W-1:0]  occ;

  // The plaintext is only committed to the reference queue once its
  // ciphertext is actually written, so an overflowed block is simply dropped.
  aes_ref_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (pt_q),
    .pop       (capture),
    .head      (q_head),
    .occ       (occ)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode; wait states leave after their configured latency.
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    fifo_we_c  = 1'b0;
    fifo_re_c  = 1'b0;
    q_push     = 1'b0;
    capture    = 1'b0;
    lat_inc    = 1'b0;
    ovf_set    = 1'b0;
    out_ack    = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept = 1'b1;
          if (ENC_LAT == 0) begin
            state_nxt = PUSH;
          end else begin
            state_nxt = ENC_WAIT;
          end
        end
      end
      LOAD: begin
        in_ready_c = (occ < OCC_FULL);
        if (in_ready_c && bus.in_valid) begin
          accept = 1'b1;
          if (ENC_LAT == 0) begin
            state_nxt = PUSH;
          end else begin
            state_nxt = ENC_WAIT;
          end
        end
      end
      ENC_WAIT: begin
        if (lat_cnt == ENC_END) begin
          state_nxt = PUSH;
        end else begin
          lat_inc = 1'b1;
        end
      end
      PUSH: begin
        if (!bus.fifo_full) begin
          fifo_we_c = 1'b1;
          q_push    = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
        if (last_q || ((occ + OCC_W'(q_push)) == OCC_FULL)) begin
          state_nxt = POP;
        end else begin
          state_nxt = LOAD;
        end
      end
      POP: begin
        if ((occ == '0) || bus.fifo_empty) begin
          state_nxt = IDLE;
        end else begin
          fifo_re_c = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == RD_END) begin
          if (DEC_LAT == 0) begin
            capture   = 1'b1;
            state_nxt = OUT;
          end else begin
            state_nxt = DEC_WAIT;
          end
        end else begin
          lat_inc = 1'b1;
        end
      end
      DEC_WAIT: begin
        if (lat_cnt == DEC_END) begin
          capture   = 1'b1;
          state_nxt = OUT;
        end else begin
          lat_inc = 1'b1;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_ack   = 1'b1;
          state_nxt = POP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latency counter restarts whenever a wait state is left or not yet entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= '0;
    end else if (lat_inc) begin
      lat_cnt <= lat_cnt + LAT_W'(1);
    end else begin
      lat_cnt <= '0;
    end
  end

  // Beat capture; the key is only taken on the first beat of a batch.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= '0;
      pt_q   <= '0;
      last_q <= 1'b0;
    end else if (accept) begin
      pt_q   <= bus.in_data;
      last_q <= bus.in_last;
      if (state == IDLE) begin
        key_q <= bus.in_key;
      end
    end
  end

  // Result register holds the decrypted block and its comparison until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_match_q <= 1'b0;
    end else if (capture) begin
      out_data_q  <= bus.dec_pt;
      out_match_q <= (bus.dec_pt == q_head);
    end
  end

  // Running statistics: delivered blocks, saturating mismatches, sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (out_ack) begin
        blk_cnt_q <= blk_cnt_q + BLK_W'(1);
        if (!out_match_q) begin
          err_cnt_q <= sat_inc(err_cnt_q);
        end
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.enc_pt    = pt_q;
  assign bus.enc_key   = key_q;
  assign bus.dec_key   = key_q;
  assign bus.fifo_we   = fifo_we_c;
  assign bus.fifo_re   = fifo_re_c;
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_match = out_match_q;
  assign bus.busy      = (state != IDLE);
  assign bus.err_cnt   = err_cnt_q;
  assign bus.blk_cnt   = blk_cnt_q;
  assign bus.ovf_err   = ovf_q;

endmodule

// File: tb/tb_aes_batch_ctrl.sv
// Directed bench for aes_batch_ctrl. The encrypt core, FIFO and decrypt core
// are modelled here with single-cycle latencies; encrypt XORs with the key
// and a mask, decrypt undoes it, so a healthy loopback returns the plaintext.
module tb_aes_batch_ctrl;
  import aes_ctrl_pkg::*;

  localparam logic [63:0] MASK = 64'hA5A5_5A5A_C3C3_3C3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_full = 1'b0;
  logic dec_corrupt = 1'b0;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int ir_bad = 0;

  logic [63:0] res_data [$];
  logic        res_match [$];

  logic [63:0] fmem [8];
  logic [2:0]  wptr, rptr;
  logic [3:0]  fcnt;
  logic [63:0] fifo_dout;

  aes_batch_ctrl_if #(.DATA_W(64)) bus ();

  aes_batch_ctrl #(
    .DATA_W  (64),
    .DEPTH   (8),
    .ENC_LAT (1),
    .RD_LAT  (1),
    .DEC_LAT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Core and FIFO models.
  always @(posedge clk) begin
    bus.enc_ct <= bus.enc_pt ^ bus.enc_key ^ MASK;
    bus.dec_pt <= fifo_dout ^ bus.dec_key ^ MASK ^ {63'd0, dec_corrupt};
    if (rst) begin
      wptr <= '0; rptr <= '0; fcnt <= '0; fifo_dout <= '0;
    end else begin
      if (bus.fifo_we && !bus.fifo_full) begin
        fmem[wptr] <= bus.enc_ct;
        wptr <= wptr + 3'd1;
      end
      if (bus.fifo_re && !bus.fifo_empty) begin
        fifo_dout <= fmem[rptr];
        rptr <= rptr + 3'd1;
      end
      fcnt <= fcnt + 4'(bus.fifo_we && !bus.fifo_full) - 4'(bus.fifo_re && !bus.fifo_empty);
    end
  end

  assign bus.fifo_full  = (fcnt == 4'd8) || force_full;
  assign bus.fifo_empty = (fcnt == 4'd0);

  // Strobe and result monitor.
  always @(posedge clk) begin
    if (bus.fifo_we) we_cnt <= we_cnt + 1;
    if (bus.fifo_re) re_cnt <= re_cnt + 1;
    if (bus.in_ready && (bus.fifo_re || bus.out_valid)) ir_bad <= ir_bad + 1;
    if (bus.out_valid && bus.out_ready) begin
      res_data.push_back(bus.out_data);
      res_match.push_back(bus.out_match);
    end
  end

  // Overall time limit.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] data, input logic [63:0] key, input logic last);
    int  n;
    logic ok;
    n = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_key   = key;
    bus.in_last  = last;
    while (!ok && n < 300) begin
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checkOutput("beat_accept", 64'(ok), 64'd1);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int base_res, base_we, base_re, n, stall_bad;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    checkOutput("rst_blk_cnt", 64'(bus.blk_cnt), 64'd0);
    checkOutput("rst_ovf", 64'(bus.ovf_err), 64'd0);
    checkOutput("rst_enc_key", bus.enc_key, 64'd0);
    checkOutput("rst_fifo_we", 64'(bus.fifo_we), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single block");
    base_we = we_cnt; base_re = re_cnt; base_res = res_data.size();
    applyStimulus(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b1);
    checkOutput("single_enc_key", bus.enc_key, 64'h1111_2222_3333_4444);
    waitIdle("single_idle");
    checkOutput("single_we", 64'(we_cnt - base_we), 64'd1);
    checkOutput("single_re", 64'(re_cnt - base_re), 64'd1);
    checkOutput("single_nres", 64'(res_data.size() - base_res), 64'd1);
    checkOutput("single_data", res_data[base_res], 64'h0123_4567_89AB_CDEF);
    checkOutput("single_match", 64'(res_match[base_res]), 64'd1);
    checkOutput("single_blk_cnt", 64'(bus.blk_cnt), 64'd1);
    checkOutput("single_err_cnt", 64'(bus.err_cnt), 64'd0);

    $display("[TB] batch of eight");
    base_we = we_cnt; base_re = re_cnt; base_res = res_data.size();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(64'(i), 64'h0F0E_0D0C_0B0A_0908, (i == 8));
    end
    checkOutput("b8_enc_key", bus.enc_key, 64'h0F0E_0D0C_0B0A_0908);
    waitIdle("b8_idle");
    checkOutput("b8_we", 64'(we_cnt - base_we), 64'd8);
    checkOutput("b8_re", 64'(re_cnt - base_re), 64'd8);
    checkOutput("b8_nres", 64'(res_data.size() - base_res), 64'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("b8_data%0d", i), res_data[base_res + i], 64'(i + 1));
      checkOutput($sformatf("b8_match%0d", i), 64'(res_match[base_res + i]), 64'd1);
    end
    checkOutput("b8_ready_in_drain", 64'(ir_bad), 64'd0);
    checkOutput("b8_blk_cnt", 64'(bus.blk_cnt), 64'd9);

    $display("[TB] nine beats without last");
    base_res = res_data.size();
    applyStimulus(64'h11, 64'hAAAA_0000_BBBB_0001, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      applyStimulus(64'h10 + 64'(i), 64'hDEAD_DEAD_DEAD_0000 + 64'(i), 1'b0);
    end
    checkOutput("b9_key_held", bus.enc_key, 64'hAAAA_0000_BBBB_0001);
    repeat (2) @(negedge clk);
    checkOutput("b9_ready_drop", 64'(bus.in_ready), 64'd0);
    applyStimulus(64'h19, 64'h5555_6666_7777_8888, 1'b1);
    checkOutput("b9_drained_first", 64'(res_data.size() - base_res), 64'd8);
    checkOutput("b9_new_key", bus.enc_key, 64'h5555_6666_7777_8888);
    waitIdle("b9_idle");
    checkOutput("b9_nres", 64'(res_data.size() - base_res), 64'd9);
    checkOutput("b9_first", res_data[base_res], 64'h11);
    checkOutput("b9_eighth", res_data[base_res + 7], 64'h18);
    checkOutput("b9_ninth", res_data[base_res + 8], 64'h19);
    checkOutput("b9_match", 64'(res_match[base_res + 8]), 64'd1);
    checkOutput("b9_blk_cnt", 64'(bus.blk_cnt), 64'd18);

    $display("[TB] output stall");
    bus.out_ready = 1'b0;
    applyStimulus(64'hCAFE_F00D_1234_5678, 64'h0101_0202_0303_0404, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
    base_re = re_cnt;
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_data !== 64'hCAFE_F00D_1234_5678 || bus.fifo_re) stall_bad++;
    end
    checkOutput("stall_stable", 64'(stall_bad), 64'd0);
    checkOutput("stall_no_re", 64'(re_cnt - base_re), 64'd0);
    checkOutput("stall_blk_cnt", 64'(bus.blk_cnt), 64'd18);
    bus.out_ready = 1'b1;
    waitIdle("stall_idle");
    checkOutput("stall_blk_after", 64'(bus.blk_cnt), 64'd19);

    $display("[TB] decrypt mismatch");
    dec_corrupt = 1'b1;
    base_res = res_data.size();
    applyStimulus(64'h0000_FFFF_0000_FFF0, 64'h1234_1234_1234_1234, 1'b1);
    waitIdle("mis_idle");
    dec_corrupt = 1'b0;
    checkOutput("mis_data", res_data[base_res], 64'h0000_FFFF_0000_FFF1);
    checkOutput("mis_match", 64'(res_match[base_res]), 64'd0);
    checkOutput("mis_err_cnt", 64'(bus.err_cnt), 64'd1);
    checkOutput("mis_blk_cnt", 64'(bus.blk_cnt), 64'd20);

    $display("[TB] forced fifo full");
    force_full = 1'b1;
    base_we = we_cnt; base_res = res_data.size();
    applyStimulus(64'h7777_7777_7777_7777, 64'h9999_9999_9999_9999, 1'b1);
    waitIdle("ovf_idle");
    force_full = 1'b0;
    checkOutput("ovf_flag", 64'(bus.ovf_err), 64'd1);
    checkOutput("ovf_no_we", 64'(we_cnt - base_we), 64'd0);
    checkOutput("ovf_occ", 64'(dut.u_queue.occ), 64'd0);
    checkOutput("ovf_no_result", 64'(res_data.size() - base_res), 64'd0);
    checkOutput("ovf_blk_cnt", 64'(bus.blk_cnt), 64'd20);

    $display("[TB] reset during read wait");
    base_re = re_cnt;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(64'hA0 + 64'(i), 64'h4242_4242_4242_4242, (i == 4));
    end
    n = 0;
    while (re_cnt < base_re + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rd3_reached", 64'(re_cnt - base_re), 64'd3);
    checkOutput("rd3_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rrst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rrst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rrst_blk_cnt", 64'(bus.blk_cnt), 64'd0);
    checkOutput("rrst_err_cnt", 64'(bus.err_cnt), 64'd0);
    checkOutput("rrst_ovf", 64'(bus.ovf_err), 64'd0);
    checkOutput("rrst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base_res = res_data.size();
    applyStimulus(64'hDEAD_BEEF_0BAD_F00D, 64'h0C0C_0C0C_0D0D_0D0D, 1'b1);
    waitIdle("post_idle");
    checkOutput("post_nres", 64'(res_data.size() - base_res), 64'd1);
    checkOutput("post_data", res_data[base_res], 64'hDEAD_BEEF_0BAD_F00D);
    checkOutput("post_match", 64'(res_match[base_res]), 64'd1);
    checkOutput("post_blk_cnt", 64'(bus.blk_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
